// File: rtl/traffic_phase_ctrl_if.sv
// Timer handshake between the phase sequencer and the down-stream interval timer.
// Ports: tmr_clr (restart timer), tmr_limit (interval for current phase),
//        tmr_done (one-cycle pulse when the interval has elapsed).
// master = sequencer side, slave = timer side.
interface traffic_phase_ctrl_if #(
  parameter int NBITS = 32
);
  logic             tmr_clr;
  logic [NBITS-1:0] tmr_limit;
  logic             tmr_done;

  modport master (output tmr_clr, output tmr_limit, input tmr_done);
  modport slave  (input tmr_clr, input tmr_limit, output tmr_done);
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Phase sequencer for a two-way (NS/EW) intersection with pedestrian walk and emergency flash.
// Ports: clk, reset (sync, active-low), ew_car_i/ped_req_i/emg_i sensor inputs, tmr timer
//        handshake (master), ns_light_o/ew_light_o one-hot {R,Y,G}, walk_o, phase_o state code.
// All outputs are registered; lamp/timer outputs are decoded from the next state.
module traffic_phase_ctrl #(
  parameter int NBITS  = 32,
  parameter int GRN_T  = 100,
  parameter int YEL_T  = 20,
  parameter int RED_T  = 5,
  parameter int WALK_T = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ew_car_i,
  input  logic                       ped_req_i,
  input  logic                       emg_i,
  traffic_phase_ctrl_if.master       tmr,
  output logic [2:0]                 ns_light_o,
  output logic [2:0]                 ew_light_o,
  output logic                       walk_o,
  output logic [2:0]                 phase_o
);

  typedef enum logic [2:0] {
    RED_A  = 3'd0,
    NS_GRN = 3'd1,
    NS_YEL = 3'd2,
    RED_B  = 3'd3,
    EW_GRN = 3'd4,
    EW_YEL = 3'd5,
    WALK   = 3'd6,
    FLASH  = 3'd7
  } state_t;

  localparam logic [NBITS-1:0] GRN_L  = NBITS'(GRN_T);
  localparam logic [NBITS-1:0] YEL_L  = NBITS'(YEL_T);
  localparam logic [NBITS-1:0] RED_L  = NBITS'(RED_T);
  localparam logic [NBITS-1:0] WALK_L = NBITS'(WALK_T);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t           state_q, state_d;
  logic             ped_pend_q, ped_pend_d;
  logic             grn_exp_q, grn_exp_d;
  logic             dir_ew_q, dir_ew_d;      // 0: next service NS, 1: next service EW
  logic             tmr_clr_q, tmr_clr_d;
  logic [NBITS-1:0] tmr_limit_q, tmr_limit_d;
  logic [2:0]       ns_light_q, ns_light_d;
  logic [2:0]       ew_light_q, ew_light_d;
  logic             walk_q, walk_d;
  logic             done;
  logic             entry;

  always_comb begin
    state_d  = state_q;
    dir_ew_d = dir_ew_q;
    // A done pulse arriving while the timer is being cleared belongs to a stale interval.
    done     = tmr.tmr_done & ~tmr_clr_q;

    case (state_q)
      RED_A: begin
        dir_ew_d = 1'b0;
        if (emg_i)     state_d = FLASH;
        else if (done) state_d = ped_pend_q ? WALK : NS_GRN;
      end
      NS_GRN: begin
        // Green is extended indefinitely until there is cross or pedestrian demand.
        if (emg_i)                                            state_d = NS_YEL;
        else if ((grn_exp_q | done) && (ew_car_i | ped_pend_q)) state_d = NS_YEL;
      end
      NS_YEL: begin
        if (done) state_d = emg_i ? FLASH : RED_B;
      end
      RED_B: begin
        dir_ew_d = 1'b1;
        if (emg_i)     state_d = FLASH;
        else if (done) state_d = ped_pend_q ? WALK : EW_GRN;
      end
      EW_GRN: begin
        if (emg_i | done) state_d = EW_YEL;
      end
      EW_YEL: begin
        if (done) state_d = emg_i ? FLASH : RED_A;
      end
      WALK: begin
        if (emg_i)     state_d = FLASH;
        else if (done) state_d = dir_ew_q ? EW_GRN : NS_GRN;
      end
      FLASH: begin
        if (!emg_i) state_d = RED_A;
      end
      default: state_d = RED_A;
    endcase

    entry = (state_d != state_q);

    // Entering WALK serves the request, including one arriving on that same edge.
    ped_pend_d = (ped_pend_q | ped_req_i) & ~(entry && (state_d == WALK));
    grn_exp_d  = entry ? 1'b0 : (grn_exp_q | (done && (state_q == NS_GRN)));

    // FLASH keeps the timer parked in clear.
    tmr_clr_d = entry | (state_d == FLASH);

    tmr_limit_d = RED_L;
    ns_light_d  = LAMP_R;
    ew_light_d  = LAMP_R;
    walk_d      = 1'b0;
    case (state_d)
      NS_GRN: begin tmr_limit_d = GRN_L;  ns_light_d = LAMP_G; end
      NS_YEL: begin tmr_limit_d = YEL_L;  ns_light_d = LAMP_Y; end
      EW_GRN: begin tmr_limit_d = GRN_L;  ew_light_d = LAMP_G; end
      EW_YEL: begin tmr_limit_d = YEL_L;  ew_light_d = LAMP_Y; end
      WALK:   begin tmr_limit_d = WALK_L; walk_d     = 1'b1;   end
      default: tmr_limit_d = RED_L;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RED_A;
      ped_pend_q  <= 1'b0;
      grn_exp_q   <= 1'b0;
      dir_ew_q    <= 1'b0;
      tmr_clr_q   <= 1'b1;
      tmr_limit_q <= RED_L;
      ns_light_q  <= LAMP_R;
      ew_light_q  <= LAMP_R;
      walk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ped_pend_q  <= ped_pend_d;
      grn_exp_q   <= grn_exp_d;
      dir_ew_q    <= dir_ew_d;
      tmr_clr_q   <= tmr_clr_d;
      tmr_limit_q <= tmr_limit_d;
      ns_light_q  <= ns_light_d;
      ew_light_q  <= ew_light_d;
      walk_q      <= walk_d;
    end
  end

  assign tmr.tmr_clr   = tmr_clr_q;
  assign tmr.tmr_limit = tmr_limit_q;
  assign ns_light_o    = ns_light_q;
  assign ew_light_o    = ew_light_q;
  assign walk_o        = walk_q;
  assign phase_o       = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: behavioural interval timer plus a dwell-count phase model.
// Ports: drives clk/reset/sensors, observes lamps, walk, phase and timer handshake.
// Random sensor/emergency/reset traffic with directed segments; summary line at the end.
module tb_traffic_phase_ctrl;

  localparam int NB     = 32;
  localparam int GRN_T  = 8;
  localparam int YEL_T  = 3;
  localparam int RED_T  = 2;
  localparam int WALK_T = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       ew_car, ped_req, emg;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk;

  traffic_phase_ctrl_if #(.NBITS(NB)) tif ();

  traffic_phase_ctrl #(
    .NBITS(NB), .GRN_T(GRN_T), .YEL_T(YEL_T), .RED_T(RED_T), .WALK_T(WALK_T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ew_car_i  (ew_car),
    .ped_req_i (ped_req),
    .emg_i     (emg),
    .tmr       (tif),
    .ns_light_o(ns_light),
    .ew_light_o(ew_light),
    .walk_o    (walk),
    .phase_o   (phase)
  );

  always #5 clk = ~clk;

  // Interval timer: done pulses once, 'limit' cycles after the edge that saw clear.
  int unsigned t_cnt  = 0;
  logic        t_done = 1'b0;
  assign tif.tmr_done = t_done;

  always @(posedge clk) begin
    if (tif.tmr_clr === 1'b1) begin
      t_cnt  <= 1;
      t_done <= (tif.tmr_limit == 1);
    end else begin
      t_cnt  <= (t_cnt < 100000) ? t_cnt + 1 : t_cnt;
      t_done <= ((t_cnt + 1) == tif.tmr_limit);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Phase model: each timed phase lasts limit+1 cycles; age 0 is the entry cycle.
  int m_ph     = 0;
  int m_age    = 0;
  bit m_ped    = 0;
  bit m_dir_ew = 0;
  bit m_valid  = 0;
  bit m_rst    = 0;
  bit emg_s    = 0;

  function automatic int lim(input int ph);
    case (ph)
      1, 4:    return GRN_T;
      2, 5:    return YEL_T;
      6:       return WALK_T;
      default: return RED_T;
    endcase
  endfunction

  function automatic logic [2:0] ns_exp(input int ph);
    return (ph == 1) ? 3'b001 : (ph == 2) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] ew_exp(input int ph);
    return (ph == 4) ? 3'b001 : (ph == 5) ? 3'b010 : 3'b100;
  endfunction

  task automatic model_step(input bit ew, input bit ped, input bit em, input bit rn);
    int nph;
    bit fin;
    if (!rn) begin
      m_ph = 0; m_age = 0; m_ped = 0; m_dir_ew = 0; m_valid = 1; m_rst = 1;
      return;
    end
    m_rst = 0;
    if (!m_valid) return;
    fin = (m_ph != 7) && (m_age == lim(m_ph));
    nph = m_ph;
    case (m_ph)
      0: if (em) nph = 7; else if (fin) nph = m_ped ? 6 : 1;
      1: if (em || (m_age >= GRN_T && (ew || m_ped))) nph = 2;
      2: if (fin) nph = em ? 7 : 3;
      3: if (em) nph = 7; else if (fin) nph = m_ped ? 6 : 4;
      4: if (em || fin) nph = 5;
      5: if (fin) nph = em ? 7 : 0;
      6: if (em) nph = 7; else if (fin) nph = m_dir_ew ? 4 : 1;
      default: if (!em) nph = 0;
    endcase
    m_ped = (m_ped || ped) && !(nph == 6 && m_ph != 6);
    if (m_ph == 0) m_dir_ew = 0;
    if (m_ph == 3) m_dir_ew = 1;
    m_age = (nph != m_ph) ? 0 : m_age + 1;
    m_ph  = nph;
  endtask

  // One clock: check outputs at the falling edge, then apply inputs for the next rising edge.
  task automatic cycle(input bit ew, input bit ped, input bit em, input bit rn);
    @(negedge clk);
    if (m_valid) begin
      check_eq("phase", 32'(phase), 32'(m_ph));
      check_eq("ns_light", 32'(ns_light), 32'(ns_exp(m_ph)));
      check_eq("ew_light", 32'(ew_light), 32'(ew_exp(m_ph)));
      check_eq("walk", 32'(walk), 32'(m_ph == 6));
      check_eq("tmr_clr", 32'(tif.tmr_clr), 32'(m_age == 0 || m_ph == 7));
      check_eq("tmr_limit", tif.tmr_limit, 32'(lim(m_ph)));
    end
    if (m_rst) begin
      check_eq("rst_phase", 32'(phase), 32'd0);
      check_eq("rst_ns", 32'(ns_light), 32'b100);
      check_eq("rst_ew", 32'(ew_light), 32'b100);
      check_eq("rst_walk", 32'(walk), 32'd0);
      check_eq("rst_clr", 32'(tif.tmr_clr), 32'd1);
      check_eq("rst_limit", tif.tmr_limit, 32'(RED_T));
    end
    ew_car  = ew;
    ped_req = ped;
    emg     = em;
    reset   = rn;
    model_step(ew, ped, em, rn);
  endtask

  // Randomised segment; all rates in per-mille.
  task automatic run(input int n, input int ew_pm, input int ped_pm, input int emg_pm, input int rst_pm);
    bit ew, pd, rn;
    for (int i = 0; i < n; i++) begin
      ew = ($urandom_range(0, 999) < ew_pm);
      pd = ($urandom_range(0, 999) < ped_pm);
      if ($urandom_range(0, 999) < emg_pm) emg_s = ~emg_s;
      rn = !($urandom_range(0, 999) < rst_pm);
      cycle(ew, pd, emg_s, rn);
    end
  endtask

  initial begin
    reset = 1'b0; ew_car = 1'b0; ped_req = 1'b0; emg = 1'b0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    run(60, 1000, 0, 0, 0);      // steady cycling with EW demand
    run(70, 0, 0, 0, 0);         // no demand: NS green holds
    run(40, 1000, 60, 0, 0);     // demand returns, pedestrian pulses
    run(400, 500, 30, 20, 0);    // emergency episodes mixed in
    emg_s = 0;
    run(10, 1000, 0, 0, 0);
    // Walk up to the middle of EW green and reset there.
    for (int i = 0; i < 200 && !(m_ph == 4 && m_age == 3); i++) cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);
    run(1500, 700, 40, 10, 3);   // everything, including random resets
    cycle(0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
